// File: rtl/lru_trace_pkg.sv
// Shared types for the trace dispatcher: default field widths, the trace-line
// record carried through the FIFO, and the dispatcher FSM states.
package lru_trace_pkg;

    localparam int TAG_W  = 17;
    localparam int IDX_W  = 11;
    localparam int INST_W = 21;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic              ls;
        logic [INST_W-1:0] inst;
    } trace_line_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/trace_line_fifo.sv
// Single-clock FIFO of trace lines. The caller only pushes when there is room
// (or a pop frees a slot in the same cycle) and only pops when non-empty.
// The head entry is presented combinationally on rdata.
module trace_line_fifo
    import lru_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  trace_line_t            wdata,
    output trace_line_t            rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    trace_line_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointer and occupancy update; a simultaneous push and pop keeps the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;

endmodule

// File: rtl/lru_trace_dispatcher.sv
// Buffers decoded trace lines and issues them to the LRU cache model over a
// valid/ready handshake, in free-run or single-step mode, while counting
// loads, stores and dropped lines and flagging the end of the trace.
module lru_trace_dispatcher #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = lru_trace_pkg::TAG_W,
    parameter int IDX_W  = lru_trace_pkg::IDX_W,
    parameter int INST_W = lru_trace_pkg::INST_W,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [IDX_W-1:0]       in_index,
    input  logic                   in_ls,
    input  logic [INST_W-1:0]      in_inst,
    input  logic                   trace_end,
    input  logic                   run_en,
    input  logic                   step,
    output logic                   req_valid,
    output logic [TAG_W-1:0]       req_tag,
    output logic [IDX_W-1:0]       req_index,
    output logic                   req_ls,
    output logic [INST_W-1:0]      req_inst,
    input  logic                   req_ready,
    output logic [CNT_W-1:0]       load_count,
    output logic [CNT_W-1:0]       store_count,
    output logic [7:0]             drop_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   done
);

    import lru_trace_pkg::*;

    state_t      state_q, state_d;
    logic        credit_q, credit_d;
    logic        te_seen_q, te_seen_d;
    logic        req_valid_q, req_valid_d;
    trace_line_t req_line_q, req_line_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] store_q, store_d;
    logic [7:0]  drop_q, drop_d;
    logic        overflow_q, overflow_d;

    trace_line_t in_line;
    trace_line_t fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic        push, pop, permit;

    assign in_line = '{tag: in_tag, index: in_index, ls: in_ls, inst: in_inst};
    assign permit  = run_en | credit_q;

    trace_line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_line),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Dispatch FSM: pops the FIFO head into the request register and retires it on handshake.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_line_d  = req_line_q;
        load_d      = load_q;
        store_d     = store_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && permit) begin
                    pop         = 1'b1;
                    req_line_d  = fifo_rdata;
                    req_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (te_seen_q && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    if (req_line_q.ls) begin
                        store_d = store_q + CNT_W'(1);
                    end else begin
                        load_d = load_q + CNT_W'(1);
                    end
                    if (!fifo_empty && permit) begin
                        pop         = 1'b1;
                        req_line_d  = fifo_rdata;
                        req_valid_d = 1'b1;
                    end else begin
                        req_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                req_valid_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Push acceptance, drop accounting, step credit and end-of-trace latch.
    always_comb begin
        push       = in_valid && (state_q != ST_DONE) && (!fifo_full || pop);
        drop_d     = drop_q;
        overflow_d = overflow_q;
        if (in_valid && !push) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
        credit_d = credit_q;
        if (pop && !run_en) begin
            credit_d = 1'b0;
        end
        if (step) begin
            credit_d = 1'b1;
        end
        te_seen_d = te_seen_q | trace_end;
    end

    // State, request and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            credit_q    <= 1'b0;
            te_seen_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_line_q  <= '0;
            load_q      <= '0;
            store_q     <= '0;
            drop_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            te_seen_q   <= te_seen_d;
            req_valid_q <= req_valid_d;
            req_line_q  <= req_line_d;
            load_q      <= load_d;
            store_q     <= store_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_tag     = req_line_q.tag;
    assign req_index   = req_line_q.index;
    assign req_ls      = req_line_q.ls;
    assign req_inst    = req_line_q.inst;
    assign load_count  = load_q;
    assign store_count = store_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_lru_trace_dispatcher.sv
// Scoreboard bench for lru_trace_dispatcher: stimulus pushes each accepted line
// into an expected queue; a negedge monitor retires one entry per handshake.
module tb_lru_trace_dispatcher;

    import lru_trace_pkg::*;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 17;
    localparam int IDX_W  = 11;
    localparam int INST_W = 21;
    localparam int CNT_W  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [TAG_W-1:0]  in_tag;
    logic [IDX_W-1:0]  in_index;
    logic              in_ls;
    logic [INST_W-1:0] in_inst;
    logic              trace_end;
    logic              run_en;
    logic              step;
    logic              req_valid;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_index;
    logic              req_ls;
    logic [INST_W-1:0] req_inst;
    logic              req_ready;
    logic [CNT_W-1:0]  load_count;
    logic [CNT_W-1:0]  store_count;
    logic [7:0]        drop_count;
    logic              overflow;
    logic [LW-1:0]     fifo_level;
    logic              done;

    always #5 clk = ~clk;

    lru_trace_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W), .INST_W(INST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_index(in_index),
        .in_ls(in_ls), .in_inst(in_inst), .trace_end(trace_end), .run_en(run_en),
        .step(step), .req_valid(req_valid), .req_tag(req_tag), .req_index(req_index),
        .req_ls(req_ls), .req_inst(req_inst), .req_ready(req_ready),
        .load_count(load_count), .store_count(store_count), .drop_count(drop_count),
        .overflow(overflow), .fifo_level(fifo_level), .done(done)
    );

    int          errors = 0;
    int          checks = 0;
    trace_line_t exp_q[$];
    int          mdl_loads = 0;
    int          mdl_stores = 0;
    int          mdl_drops = 0;
    int          hs_count = 0;
    int          hs_base;
    bit          mon_en = 1'b0;
    bit          stalled = 1'b0;
    trace_line_t stall_line;
    trace_line_t cur_line;
    trace_line_t exp_line;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake retires the oldest expected line; stalls must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_line = '{tag: req_tag, index: req_index, ls: req_ls, inst: req_inst};
            if (stalled) begin
                checkOutput("hold_valid", 64'(req_valid), 64'd1);
                checkOutput("hold_payload", 64'(cur_line), 64'(stall_line));
            end
            stalled = 1'b0;
            if (req_valid) begin
                if (req_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_req", 64'(cur_line), 64'd0);
                    end else begin
                        exp_line = exp_q.pop_front();
                        checkOutput("req_payload", 64'(cur_line), 64'(exp_line));
                        if (exp_line.ls) mdl_stores++;
                        else mdl_loads++;
                    end
                end else begin
                    stalled    = 1'b1;
                    stall_line = cur_line;
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // One-cycle line pulse; accepted lines become expected requests.
    task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                                 input logic ls, input logic [INST_W-1:0] inst, input bit accept);
        trace_line_t e;
        in_tag   = tag;
        in_index = idx;
        in_ls    = ls;
        in_inst  = inst;
        in_valid = 1'b1;
        e = '{tag: tag, index: idx, ls: ls, inst: inst};
        if (accept) exp_q.push_back(e);
        else mdl_drops++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic applyRandom(input bit accept);
        applyStimulus(TAG_W'($urandom()), IDX_W'($urandom()), 1'($urandom_range(0, 1)),
                      INST_W'($urandom()), accept);
    endtask

    task automatic waitValid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (req_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("wait_req_valid", 64'(seen), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        checkOutput({tag, "_load"}, 64'(load_count), 64'd0);
        checkOutput({tag, "_store"}, 64'(store_count), 64'd0);
        checkOutput({tag, "_drop"}, 64'(drop_count), 64'd0);
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
        checkOutput({tag, "_level"}, 64'(fifo_level), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_req_payload"}, 64'({req_tag, req_index, req_ls, req_inst}), 64'd0);
    endtask

    task automatic clearModel();
        exp_q.delete();
        mdl_loads  = 0;
        mdl_stores = 0;
        mdl_drops  = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_index = '0; in_ls = 1'b0; in_inst = '0;
        trace_end = 1'b0; run_en = 1'b0; step = 1'b0; req_ready = 1'b0;
        repeat (3) tick();
        sample();
        checkAllZero("reset");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Free-run: three lines, first request two cycles after the push.
        run_en = 1'b1; req_ready = 1'b1;
        applyStimulus(17'h1, 11'h10, 1'b0, 21'h111, 1'b1);
        sample();
        checkOutput("first_req_t1", 64'(req_valid), 64'd0);
        tick();
        sample();
        checkOutput("first_req_t2", 64'(req_valid), 64'd1);
        checkOutput("first_req_tag", 64'(req_tag), 64'h1);
        tick();
        applyStimulus(17'h2, 11'h20, 1'b1, 21'h222, 1'b1);
        applyStimulus(17'h3, 11'h30, 1'b0, 21'h333, 1'b1);
        repeat (5) tick();
        sample();
        checkOutput("freerun_loads", 64'(load_count), 64'd2);
        checkOutput("freerun_stores", 64'(store_count), 64'd1);
        tick();

        // Backpressure: request held for five cycles, then exactly one count added.
        req_ready = 1'b0;
        applyStimulus(17'h4, 11'h40, 1'b1, 21'h444, 1'b1);
        waitValid(10);
        repeat (5) tick();
        sample();
        checkOutput("bp_loads_held", 64'(load_count), 64'd2);
        checkOutput("bp_stores_held", 64'(store_count), 64'd1);
        tick();
        req_ready = 1'b1;
        repeat (3) tick();
        sample();
        checkOutput("bp_loads_after", 64'(load_count), 64'd2);
        checkOutput("bp_stores_after", 64'(store_count), 64'd2);
        checkOutput("bp_valid_after", 64'(req_valid), 64'd0);
        tick();

        // Step mode: no issue without credit; two step pulses give two issues.
        run_en = 1'b0; req_ready = 1'b0;
        repeat (4) applyRandom(1'b1);
        repeat (3) tick();
        sample();
        checkOutput("step_no_req", 64'(req_valid), 64'd0);
        checkOutput("step_level4", 64'(fifo_level), 64'd4);
        tick();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        repeat (3) tick();
        sample();
        checkOutput("step_req_up", 64'(req_valid), 64'd1);
        checkOutput("step_level3", 64'(fifo_level), 64'd3);
        tick();
        hs_base = hs_count;
        req_ready = 1'b1;
        repeat (6) tick();
        sample();
        checkOutput("step_two_issues", 64'(hs_count - hs_base), 64'd2);
        checkOutput("step_level2", 64'(fifo_level), 64'd2);
        checkOutput("step_valid_low", 64'(req_valid), 64'd0);
        checkOutput("step_loads", 64'(load_count), 64'(mdl_loads));
        checkOutput("step_stores", 64'(store_count), 64'(mdl_stores));
        tick();
        run_en = 1'b1;
        repeat (6) tick();
        sample();
        checkOutput("step_drained", 64'(fifo_level), 64'd0);
        tick();

        // Overflow: DEPTH+3 pushes with nothing leaving, then push+pop while full.
        run_en = 1'b0; req_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) applyRandom(i < DEPTH);
        sample();
        checkOutput("ovf_drops", 64'(drop_count), 64'(mdl_drops));
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_level", 64'(fifo_level), 64'(DEPTH));
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        applyRandom(1'b1);
        sample();
        checkOutput("full_pushpop_drops", 64'(drop_count), 64'd3);
        checkOutput("full_pushpop_level", 64'(fifo_level), 64'(DEPTH));
        tick();
        run_en = 1'b1; req_ready = 1'b1;
        repeat (DEPTH + 5) tick();
        sample();
        checkOutput("ovf_drained", 64'(fifo_level), 64'd0);
        checkOutput("ovf_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("ovf_loads", 64'(load_count), 64'(mdl_loads));
        checkOutput("ovf_stores", 64'(store_count), 64'(mdl_stores));
        tick();

        // Reset while a request is outstanding clears everything.
        req_ready = 1'b0;
        applyRandom(1'b1);
        waitValid(10);
        tick();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        checkAllZero("mid_rst");
        clearModel();
        tick();
        mon_en = 1'b1;

        // Done: trace_end with two lines queued; done only after both handshakes.
        run_en = 1'b1; req_ready = 1'b0;
        applyRandom(1'b1);
        applyRandom(1'b1);
        trace_end = 1'b1;
        tick();
        trace_end = 1'b0;
        repeat (3) tick();
        sample();
        checkOutput("done_early", 64'(done), 64'd0);
        tick();
        hs_base = hs_count;
        req_ready = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                sample();
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            checkOutput("done_rise", 64'(seen), 64'd1);
        end
        checkOutput("done_after_two_hs", 64'(hs_count - hs_base), 64'd2);
        checkOutput("done_req_low", 64'(req_valid), 64'd0);
        tick();
        applyRandom(1'b0);
        sample();
        checkOutput("done_drop", 64'(drop_count), 64'(mdl_drops));
        checkOutput("done_held", 64'(done), 64'd1);
        checkOutput("done_level", 64'(fifo_level), 64'd0);
        tick();

        // Randomized traffic with random backpressure, mode and step pulses.
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clearModel();
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            req_ready = ($urandom_range(0, 3) != 0);
            run_en    = ($urandom_range(0, 7) != 0);
            step      = ($urandom_range(0, 3) == 0);
            if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
                trace_line_t e;
                in_tag   = TAG_W'($urandom());
                in_index = IDX_W'($urandom());
                in_ls    = 1'($urandom_range(0, 1));
                in_inst  = INST_W'($urandom());
                in_valid = 1'b1;
                e = '{tag: in_tag, index: in_index, ls: in_ls, inst: in_inst};
                exp_q.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; step = 1'b0; run_en = 1'b1; req_ready = 1'b1;
        repeat (DEPTH + 6) tick();
        sample();
        checkOutput("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("rand_loads", 64'(load_count), 64'(mdl_loads));
        checkOutput("rand_stores", 64'(store_count), 64'(mdl_stores));
        checkOutput("rand_drops", 64'(drop_count), 64'd0);
        checkOutput("rand_level", 64'(fifo_level), 64'd0);
        checkOutput("rand_valid_low", 64'(req_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lru_trace_dispatcher.md
# lru_trace_dispatcher

Sequences parsed trace lines from the SD-card decoder into the LRU cache model. A DEPTH-entry FIFO absorbs decoder line pulses. A small FSM issues entries to the cache over a valid/ready handshake, in either free-running or single-step mode. It also keeps load, store and dropped-line counters and raises `done` once the trace is exhausted.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `TAG_W`, 17: tag width.
- `IDX_W`, 11: index width.
- `INST_W`, 21: instruction field width.
- `CNT_W`, 16: load/store counter width.

Ports:
- `clk` in 1: single clock; every flop is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: one-cycle pulse from the decoder marking a parsed line.
- `in_tag` in TAG_W: tag, sampled with `in_valid`.
- `in_index` in IDX_W: index, sampled with `in_valid`.
- `in_ls` in 1: 1 = store, 0 = load; sampled with `in_valid`.
- `in_inst` in INST_W: instruction field, sampled with `in_valid`.
- `trace_end` in 1: pulse or level meaning the decoder has no more lines.
- `run_en` in 1: 1 = free-run, 0 = step mode.
- `step` in 1: one-cycle pulse; grants one issue while in step mode.
- `req_valid` out 1: request to the cache is valid.
- `req_tag` out TAG_W: request tag.
- `req_index` out IDX_W: request index.
- `req_ls` out 1: request load/store flag.
- `req_inst` out INST_W: request instruction field.
- `req_ready` in 1: the cache accepts the request.
- `load_count` out CNT_W: completed loads.
- `store_count` out CNT_W: completed stores.
- `drop_count` out 8: lines lost to overflow.
- `overflow` out 1: sticky flag, set on any dropped line.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `done` out 1: trace fully dispatched.

## Operation
- Reset values:
  - All outputs are 0: `req_*`, counters, `overflow`, `fifo_level`, `done`.
  - FIFO is empty, FSM is in IDLE, step credit is 0, `trace_end_seen` is 0.
- FIFO push:
  - Occurs on `in_valid` when not full, or when full but a pop happens in the same cycle.
  - Otherwise the line is dropped: `drop_count` increments (saturates at 255) and `overflow` is set.
  - Simultaneous push and pop leaves the level unchanged.
- Issue permission: `run_en` = 1, or step credit = 1.
  - The step credit is one bit. `step` sets it; a pop in step mode clears it.
  - `step` while credit is already 1 is ignored; credits do not accumulate.
  - `step` arriving in the same cycle as a credit-consuming pop leaves credit at 1.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If the FIFO is non-empty and issue is permitted: pop the head into the `req_*` registers, set `req_valid` = 1, go to ISSUE.
  - Else if `trace_end_seen` is set and the FIFO is empty: go to DONE.
- ISSUE:
  - `req_valid` and the `req_*` payload stay stable until `req_ready`.
  - On the `req_ready` handshake: increment `load_count` or `store_count` per `req_ls` (wrap-around at 2^CNT_W).
  - After the handshake, if the FIFO is non-empty and issue is permitted: pop the next entry in the same cycle and stay in ISSUE with `req_valid` = 1 (back-to-back).
  - Otherwise after the handshake: `req_valid` = 0 and go to IDLE.
- DONE:
  - `done` = 1 and `req_valid` = 0.
  - Further `in_valid` pulses are dropped and counted as drops.
  - DONE is exited only by `rst`.
- `trace_end` is latched sticky into `trace_end_seen`. Lines still queued are dispatched before DONE is entered.
- Clearing `run_en` while in ISSUE does not cancel the outstanding request. It only blocks the next pop.

## Timing
- `in_valid` at cycle t → FIFO entry visible at t+1.
- With an empty FIFO, FSM in IDLE and `run_en` = 1, `req_valid` rises at t+2 (pop at the t+1 edge).
- Throughput: one request per cycle while `req_ready` is held high and the FIFO is non-empty.
- Counters update on the edge after the handshake cycle.
- `done` rises one cycle after IDLE observes `trace_end_seen` with an empty FIFO.
- `rst` mid-transaction: `req_valid` is 0 on the next cycle, FIFO contents are discarded, counters are cleared.
- `fifo_level` is registered and reflects pushes and pops of the previous edge.

## Structure
- Package `lru_trace_pkg` holds:
  - The default widths: `TAG_W`, `IDX_W`, `INST_W`.
  - A packed trace-line struct: tag, index, ls, inst.
  - The FSM state enum: IDLE, ISSUE, DONE.
- Sub-module `trace_line_fifo`: a synchronous single-clock FIFO of that struct, with full, empty and level outputs. The dispatcher contains the FSM, the step-credit logic and the counters.

## Test plan
- Free-run: push 3 lines (tag 0x1, 0x2, 0x3; ls = 0, 1, 0) with `req_ready` = 1. Required: `req_valid` rises 2 cycles after the first push, requests are in order, `load_count` = 2, `store_count` = 1.
- Backpressure: hold `req_ready` = 0 for 5 cycles after `req_valid` rises. Required: payload stays stable and no counter changes. Then assert `req_ready`; exactly one count is added.
- Step mode: with `run_en` = 0, push 4 lines; there is no request until `step`. Two `step` pulses 1 cycle apart while ISSUE is stalled yield exactly 2 issues total.
- Overflow: push DEPTH + 3 lines back-to-back with `req_ready` = 0 and `run_en` = 0. Required: `drop_count` = 3, `overflow` = 1, `fifo_level` = DEPTH. Also push and pop in the same cycle while full; required: no drop.
- Done and reset: pulse `trace_end` with 2 lines queued. Required: `done` rises only after both handshakes; a later `in_valid` increments `drop_count`. Assert `rst` during ISSUE; required: all outputs are 0 on the next cycle.
